// File: rtl/ysyx_22040088_pkg.sv
// ysyx_22040088_pkg: shared PCU types, forwarding encodings and operand source selection.
package ysyx_22040088_pkg;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2
    } pcu_state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [4:0] REG_ZERO  = 5'd0;

    // The younger producer (EX/MEM) shadows the older one (MEM/WB); x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic mem_wen,
                                           input logic [4:0] mem_rd, input logic wb_wen,
                                           input logic [4:0] wb_rd);
        return (mem_wen && mem_rd != REG_ZERO && mem_rd == rs) ? FWD_EXMEM :
               (wb_wen && wb_rd != REG_ZERO && wb_rd == rs)    ? FWD_MEMWB : FWD_RF;
    endfunction

endpackage

// File: rtl/ysyx_22040088_pcu_hzd.sv
// ysyx_22040088_pcu_hzd: combinational load-use detection and per-operand forwarding select.
module ysyx_22040088_pcu_hzd (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [1:0] id_rs_used,
    input  logic [4:0] ex_rd,
    input  logic [4:0] mem_rd,
    input  logic [4:0] wb_rd,
    input  logic       ex_rf_wen,
    input  logic       mem_rf_wen,
    input  logic       wb_rf_wen,
    input  logic       ex_is_load,
    output logic       load_use,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);
    import ysyx_22040088_pkg::*;

    assign load_use = ex_is_load && ex_rf_wen && ex_rd != REG_ZERO &&
                      ((id_rs_used[0] && ex_rd == id_rs1) || (id_rs_used[1] && ex_rd == id_rs2));
    assign fwd_a = fwd_sel(id_rs1, mem_rf_wen, mem_rd, wb_rf_wen, wb_rd);
    assign fwd_b = fwd_sel(id_rs2, mem_rf_wen, mem_rd, wb_rf_wen, wb_rd);

endmodule

// File: rtl/ysyx_22040088_pcu.sv
// ysyx_22040088_pcu: pipeline control unit (stall/flush/freeze FSM, forwarding, halt).
// Optional perf counters are built only with YSYX_22040088_PCU_PERF_EN defined.
module ysyx_22040088_pcu (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [1:0]  id_rs_used,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  mem_rd,
    input  logic [4:0]  wb_rd,
    input  logic        ex_rf_wen,
    input  logic        mem_rf_wen,
    input  logic        wb_rf_wen,
    input  logic        ex_is_load,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        wb_ebreak,
    output logic        pc_ena,
    output logic        sel_redirect,
    output logic        id_ena,
    output logic        ex_ena,
    output logic        mem_ena,
    output logic        wb_ena,
    output logic        id_valid,
    output logic        ex_valid,
    output logic        mem_valid,
    output logic        wb_valid,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        halted,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);
    import ysyx_22040088_pkg::*;

    pcu_state_e state_q, state_d;
    logic       load_use, freeze, drain;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    ysyx_22040088_pcu_hzd u_hzd (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rs_used (id_rs_used),
        .ex_rd      (ex_rd),
        .mem_rd     (mem_rd),
        .wb_rd      (wb_rd),
        .ex_rf_wen  (ex_rf_wen),
        .mem_rf_wen (mem_rf_wen),
        .wb_rf_wen  (wb_rf_wen),
        .ex_is_load (ex_is_load),
        .load_use   (load_use),
        .fwd_a      (fwd_a_raw),
        .fwd_b      (fwd_b_raw)
    );

    assign freeze = !mem_ready && ((state_q == S_RUN && mem_req) || state_q == S_MEM_WAIT);
    // Completion cycle: MEM retires into WB while PC/ID/EX stay put so a pending redirect survives.
    assign drain  = state_q == S_MEM_WAIT && mem_ready;
    assign fwd_a  = rst ? fwd_a_raw : FWD_RF;
    assign fwd_b  = rst ? fwd_b_raw : FWD_RF;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d      = (state_q == S_HALT || wb_ebreak) ? S_HALT : freeze ? S_MEM_WAIT : S_RUN;
        pc_ena       = 1'b1;
        sel_redirect = 1'b0;
        id_ena       = 1'b1;
        ex_ena       = 1'b1;
        mem_ena      = 1'b1;
        wb_ena       = 1'b1;
        id_valid     = 1'b1;
        ex_valid     = 1'b1;
        mem_valid    = 1'b1;
        wb_valid     = 1'b1;
        halted       = 1'b0;
        if (!rst || state_q == S_HALT) begin
            pc_ena    = 1'b0;
            id_ena    = 1'b0;
            ex_ena    = 1'b0;
            mem_ena   = 1'b0;
            wb_ena    = 1'b0;
            id_valid  = 1'b0;
            ex_valid  = 1'b0;
            mem_valid = 1'b0;
            wb_valid  = 1'b0;
            halted    = rst;
        end else if (freeze) begin
            pc_ena   = 1'b0;
            id_ena   = 1'b0;
            ex_ena   = 1'b0;
            mem_ena  = 1'b0;
            wb_valid = 1'b0;
        end else if (drain) begin
            pc_ena    = 1'b0;
            id_ena    = 1'b0;
            ex_ena    = 1'b0;
            mem_valid = 1'b0;
        end else if (ex_redirect) begin
            sel_redirect = 1'b1;
            id_valid     = 1'b0;
            ex_valid     = 1'b0;
        end else if (load_use) begin
            pc_ena   = 1'b0;
            id_ena   = 1'b0;
            ex_valid = 1'b0;
        end
    end

`ifdef YSYX_22040088_PCU_PERF_EN
    logic [31:0] stall_q, stall_d, flush_q, flush_d;

    assign stall_d = (!pc_ena && state_q != S_HALT) ? stall_q + 32'd1 : stall_q;
    assign flush_d = sel_redirect ? flush_q + 32'd1 : flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_22040088_pcu.sv
// tb_ysyx_22040088_pcu: directed self-checking bench for the pipeline control unit.
module tb_ysyx_22040088_pcu;

`ifdef YSYX_22040088_PCU_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // ctl = {pc_ena, sel_redirect, id,ex,mem,wb ena, id,ex,mem,wb valid, halted}
    localparam logic [10:0] C_RST  = 11'b0_0_0000_0000_0;
    localparam logic [10:0] C_RUN  = 11'b1_0_1111_1111_0;
    localparam logic [10:0] C_LU   = 11'b0_0_0111_1011_0;
    localparam logic [10:0] C_RDIR = 11'b1_1_1111_0011_0;
    localparam logic [10:0] C_FRZ  = 11'b0_0_0001_1110_0;
    localparam logic [10:0] C_DRN  = 11'b0_0_0011_1101_0;
    localparam logic [10:0] C_HALT = 11'b0_0_0000_0000_1;

    logic        clk = 1'b0, rst = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0, mem_rd = '0, wb_rd = '0;
    logic [1:0]  id_rs_used = '0;
    logic        ex_rf_wen = 0, mem_rf_wen = 0, wb_rf_wen = 0, ex_is_load = 0;
    logic        ex_redirect = 0, mem_req = 0, mem_ready = 0, wb_ebreak = 0;
    logic        pc_ena, sel_redirect, id_ena, ex_ena, mem_ena, wb_ena;
    logic        id_valid, ex_valid, mem_valid, wb_valid, halted;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;
    logic [10:0] ctl;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_ena, sel_redirect, id_ena, ex_ena, mem_ena, wb_ena,
                  id_valid, ex_valid, mem_valid, wb_valid, halted};

    ysyx_22040088_pcu dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs_used(id_rs_used),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_rf_wen(ex_rf_wen),
        .mem_rf_wen(mem_rf_wen), .wb_rf_wen(wb_rf_wen), .ex_is_load(ex_is_load),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_ebreak(wb_ebreak), .pc_ena(pc_ena), .sel_redirect(sel_redirect),
        .id_ena(id_ena), .ex_ena(ex_ena), .mem_ena(mem_ena), .wb_ena(wb_ena),
        .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic set_lu(input logic on);
        ex_is_load = on; ex_rf_wen = on; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs_used = 2'b01;
    endtask

    initial begin
        mem_rf_wen = 1; mem_rd = 5'd7; id_rs2 = 5'd7;
        repeat (2) tick();
        chk("rst_ctl", 32'(ctl), 32'(C_RST));
        chk("rst_fwd_b", 32'(fwd_b), 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_flush", flush_cnt, 32'd0);
        mem_rf_wen = 0; mem_rd = 0; id_rs2 = 0;
        rst = 1; #1;
        chk("run_ctl", 32'(ctl), 32'(C_RUN));

        set_lu(1); id_rs_used = 2'b10; #1;
        chk("lu_unused_rs1", 32'(ctl), 32'(C_RUN));
        id_rs_used = 2'b01; #1;
        chk("lu_ctl", 32'(ctl), 32'(C_LU));
        tick();
        chk("lu_stall", stall_cnt, cnt(1));
        set_lu(0); #1;
        chk("lu_after", 32'(ctl), 32'(C_RUN));
        ex_is_load = 1; ex_rf_wen = 1; ex_rd = 5'd9; id_rs2 = 5'd9; id_rs_used = 2'b10; #1;
        chk("lu_rs2", 32'(ctl), 32'(C_LU));
        ex_rd = 5'd0; id_rs2 = 5'd0; #1;
        chk("lu_x0", 32'(ctl), 32'(C_RUN));

        set_lu(1); ex_redirect = 1; #1;
        chk("rdir_over_lu", 32'(ctl), 32'(C_RDIR));
        tick();
        chk("rdir_stall", stall_cnt, cnt(1));
        chk("rdir_flush", flush_cnt, cnt(1));
        set_lu(0); id_rs_used = 0; id_rs1 = 0;

        mem_req = 1; mem_ready = 0; #1;
        chk("frz1", 32'(ctl), 32'(C_FRZ));
        tick();
        chk("frz2", 32'(ctl), 32'(C_FRZ));
        tick();
        chk("frz3", 32'(ctl), 32'(C_FRZ));
        tick();
        mem_ready = 1; #1;
        chk("drain", 32'(ctl), 32'(C_DRN));
        tick();
        mem_req = 0; mem_ready = 0; #1;
        chk("deferred_rdir", 32'(ctl), 32'(C_RDIR));
        tick();
        ex_redirect = 0; #1;
        chk("post_wait", 32'(ctl), 32'(C_RUN));
        chk("wait_flush", flush_cnt, cnt(2));
        chk("wait_stall", stall_cnt, cnt(5));

        mem_rf_wen = 1; wb_rf_wen = 1; mem_rd = 5'd7; wb_rd = 5'd7; id_rs2 = 5'd7; #1;
        chk("fwd_b_exmem", 32'(fwd_b), 32'b01);
        chk("fwd_a_rf", 32'(fwd_a), 32'b00);
        mem_rd = 0; wb_rd = 0; #1;
        chk("fwd_b_x0", 32'(fwd_b), 32'b00);
        wb_rd = 5'd7; #1;
        chk("fwd_b_memwb", 32'(fwd_b), 32'b10);
        mem_rd = 5'd7; mem_rf_wen = 0; #1;
        chk("fwd_b_nowen", 32'(fwd_b), 32'b10);
        id_rs1 = 5'd3; mem_rd = 5'd3; mem_rf_wen = 1; #1;
        chk("fwd_a_exmem", 32'(fwd_a), 32'b01);
        mem_rf_wen = 0; wb_rf_wen = 0; mem_rd = 0; wb_rd = 0; id_rs1 = 0; id_rs2 = 0;

        wb_ebreak = 1; #1;
        chk("ebreak_cycle", 32'(ctl), 32'(C_RUN));
        tick();
        wb_ebreak = 0; #1;
        chk("halt1", 32'(ctl), 32'(C_HALT));
        tick();
        chk("halt2", 32'(ctl), 32'(C_HALT));
        chk("halt_stall", stall_cnt, cnt(5));
        rst = 0; #1;
        chk("halt_rst_ctl", 32'(ctl), 32'(C_RST));
        chk("halt_rst_stall", stall_cnt, 32'd0);
        tick();
        rst = 1; #1;
        chk("after_rst", 32'(ctl), 32'(C_RUN));

        set_lu(1);
        repeat (100) tick();
        chk("stall100", stall_cnt, cnt(100));
        chk("flush100", flush_cnt, 32'd0);
        set_lu(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
